// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
// Accepts a byte stream (valid/ready), assembles big-endian 32-bit words
// and writes them to the instruction RAM. The stream starts with a 4-byte
// word count N followed by N words. The CPU is held in reset until the
// image is fully loaded.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle pulse that begins a load (IDLE/DONE/ERR)
//   in_valid/in_data  stream byte and its qualifier
//   in_ready          loader accepts a byte this cycle (registered)
//   im_we/im_a/im_d   RAM write port (one-cycle write pulse per word)
//   im_byte_addr      CPU-visible byte address of the current write
//   cpu_rst           CPU reset, released only in DONE
//   done              image fully loaded
//   err               header word count exceeds DEPTH
module imem_loader #(
  parameter logic [31:0] BASE  = 32'h00400000,
  parameter int          AW    = 11,
  parameter int          DEPTH = 2048
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          im_we,
  output logic [AW-1:0] im_a,
  output logic [31:0]   im_d,
  output logic [31:0]   im_byte_addr,
  output logic          cpu_rst,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [31:0] DEPTH32 = 32'(DEPTH);

  state_t      state, state_n;
  logic [23:0] asm_q;      // three most recent bytes of the word in progress
  logic [31:0] n_q;        // latched word count
  logic [1:0]  bcnt;
  logic [AW:0] idx;        // one extra bit so N == DEPTH ends without wrap

  logic          acc;
  logic          last_byte;
  logic [31:0]   word;
  logic [AW:0]   idx_inc;

  assign acc       = in_valid && in_ready;
  assign last_byte = acc && (bcnt == 2'd3);
  assign word      = {asm_q, in_data};
  assign idx_inc   = idx + 1'b1;

  assign im_byte_addr = BASE + (32'(im_a) << 2);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start) state_n = S_HDR;
      S_HDR: begin
        if (last_byte) begin
          if (word == '0)          state_n = S_DONE;
          else if (word > DEPTH32) state_n = S_ERR;
          else                     state_n = S_DATA;
        end
      end
      S_DATA: if (last_byte && (32'(idx_inc) == n_q)) state_n = S_DONE;
      S_DONE: if (start) state_n = S_HDR;
      S_ERR:  if (start) state_n = S_HDR;
      default: state_n = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they change on the
  // same edge as the state itself; in_ready therefore never sees in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready <= 1'b0;
      im_we    <= 1'b0;
      im_a     <= '0;
      im_d     <= '0;
      cpu_rst  <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      asm_q    <= '0;
      n_q      <= '0;
      bcnt     <= '0;
      idx      <= '0;
    end else begin
      im_we    <= 1'b0;
      in_ready <= (state_n == S_HDR) || (state_n == S_DATA);
      done     <= (state_n == S_DONE);
      err      <= (state_n == S_ERR);
      cpu_rst  <= (state_n != S_DONE);

      if (acc) begin
        asm_q <= word[23:0];
        bcnt  <= bcnt + 2'd1;
      end

      if (start && (state == S_IDLE || state == S_DONE || state == S_ERR)) begin
        bcnt <= '0;
        idx  <= '0;
      end

      if (state == S_HDR && last_byte) begin
        n_q <= word;
        idx <= '0;
      end

      if (state == S_DATA && last_byte) begin
        im_we <= 1'b1;
        im_a  <= idx[AW-1:0];
        im_d  <= word;
        idx   <= idx_inc;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed load sequences with random word
// contents and random in_valid gaps, compared against an expected write
// list derived from the stream format.
module tb_imem_loader;

  localparam logic [31:0] BASE  = 32'h00400000;
  localparam int          AW    = 11;
  localparam int          DEPTH = 2048;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_ready;
  logic          im_we;
  logic [AW-1:0] im_a;
  logic [31:0]   im_d;
  logic [31:0]   im_byte_addr;
  logic          cpu_rst;
  logic          done;
  logic          err;

  imem_loader #(.BASE(BASE), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .im_we(im_we), .im_a(im_a), .im_d(im_d), .im_byte_addr(im_byte_addr),
    .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] ba;
    logic        dn;
    logic        cr;
    int          cyc;
  } wr_t;

  wr_t         wq[$];
  int          cyc = 0;
  logic [31:0] words [0:DEPTH-1];

  // Record every cycle in which a write is presented.
  always @(negedge clk) begin
    wr_t w;
    cyc++;
    if (im_we) begin
      w.a = 32'(im_a); w.d = im_d; w.ba = im_byte_addr;
      w.dn = done; w.cr = cpu_rst; w.cyc = cyc;
      wq.push_back(w);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int g;
    int t;
    g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    repeat (g) begin @(negedge clk); in_valid = 1'b0; end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) chk("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    send_byte(w[31:24], maxgap);
    send_byte(w[23:16], maxgap);
    send_byte(w[15:8],  maxgap);
    send_byte(w[7:0],   maxgap);
  endtask

  // Send header n plus (if legal) n words from words[], then compare the
  // captured writes with the list the stream format implies.
  task automatic load(input logic [31:0] n, input int maxgap, input bit do_start);
    int nexp;
    int nchk;
    wq.delete();
    if (do_start) pulse_start();
    send_word(n, maxgap);
    nexp = (n <= 32'(DEPTH)) ? int'(n) : 0;
    for (int i = 0; i < nexp; i++) send_word(words[i], maxgap);
    repeat (3) @(negedge clk);
    chk("nwrites", 32'(wq.size()), 32'(nexp));
    nchk = (wq.size() < nexp) ? wq.size() : nexp;
    for (int i = 0; i < nchk; i++) begin
      chk("wr_a",  wq[i].a,  32'(i));
      chk("wr_d",  wq[i].d,  words[i]);
      chk("wr_ba", wq[i].ba, BASE + 32'(4 * i));
      chk("wr_done",    32'(wq[i].dn), (i == nexp - 1) ? 32'd1 : 32'd0);
      chk("wr_cpu_rst", 32'(wq[i].cr), (i == nexp - 1) ? 32'd0 : 32'd1);
      if (i > 0) chk("wr_spacing", 32'(wq[i].cyc - wq[i-1].cyc >= 4), 32'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_im_we"},    32'(im_we),    32'd0);
    chk({tag, "_im_a"},     32'(im_a),     32'd0);
    chk({tag, "_im_d"},     im_d,          32'd0);
    chk({tag, "_ba"},       im_byte_addr,  BASE);
    chk({tag, "_cpu_rst"},  32'(cpu_rst),  32'd1);
    chk({tag, "_done"},     32'(done),     32'd0);
    chk({tag, "_err"},      32'(err),      32'd0);
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Two-word image, no gaps
    words[0] = 32'h3C010040;
    words[1] = 32'h20210001;
    load(32'd2, 0, 1'b1);
    chk("n2_done",     32'(done),     32'd1);
    chk("n2_cpu_rst",  32'(cpu_rst),  32'd0);
    chk("n2_in_ready", 32'(in_ready), 32'd0);

    // Empty image
    load(32'd0, 0, 1'b1);
    chk("n0_done",    32'(done),    32'd1);
    chk("n0_cpu_rst", 32'(cpu_rst), 32'd0);

    // Oversized header
    load(32'd2049, 0, 1'b1);
    chk("ovf_err",      32'(err),      32'd1);
    chk("ovf_in_ready", 32'(in_ready), 32'd0);
    chk("ovf_cpu_rst",  32'(cpu_rst),  32'd1);
    chk("ovf_done",     32'(done),     32'd0);
    pulse_start();
    chk("ovf_clr_err",   32'(err),      32'd0);
    chk("ovf_clr_ready", 32'(in_ready), 32'd1);

    // N=3 random words, already in HDR: first gap-free, then with gaps
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    load(32'd3, 0, 1'b0);
    load(32'd3, 5, 1'b1);

    // Reset mid-word
    wq.delete();
    for (int i = 0; i < 2; i++) words[i] = $urandom;
    pulse_start();
    send_word(32'd2, 0);
    send_word(words[0], 0);
    send_byte(8'hA5, 0);
    send_byte(8'h5A, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_nwrites", 32'(wq.size()), 32'd1);
    words[0] = $urandom;
    load(32'd1, 0, 1'b1);

    // Full-depth image
    for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
    load(32'(DEPTH), 0, 1'b1);
    if (wq.size() == DEPTH) begin
      chk("full_last_a",  wq[DEPTH-1].a,  32'(DEPTH - 1));
      chk("full_last_ba", wq[DEPTH-1].ba, 32'h00401FFC);
    end else begin
      chk("full_count", 32'(wq.size()), 32'(DEPTH));
    end
    chk("full_done", 32'(done), 32'd1);
    pulse_start();
    chk("restart_cpu_rst",  32'(cpu_rst),  32'd1);
    chk("restart_done",     32'(done),     32'd0);
    chk("restart_in_ready", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Writer side of the instruction memory. Accepts a byte stream over a valid/ready handshake, assembles 32-bit big-endian instruction words, and drives the write port of the instruction RAM at word index `(byte_addr - BASE) >> 2`. The CPU fetch path reads that RAM. The block holds the CPU in reset while a program image is loading and releases it once the last word is written.

## Interface
Parameters:
- `BASE`, `32'h00400000`: byte address of word 0; this is the reset PC.
- `AW`, `11`: word-address width of the RAM write port.
- `DEPTH`, `2048`: RAM capacity in words; must equal `2**AW`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a load.
- `in_valid` in 1: a stream byte is present.
- `in_data` in 8: stream byte.
- `in_ready` out 1: loader can accept a byte this cycle.
- `im_we` out 1: RAM write enable, one-cycle pulse per word.
- `im_a` out AW: RAM word address.
- `im_d` out 32: RAM write data.
- `im_byte_addr` out 32: CPU-visible byte address of the current write, equal to `BASE + 4*im_a`.
- `cpu_rst` out 1: hold CPU in reset.
- `done` out 1: image fully loaded.
- `err` out 1: header word count exceeds `DEPTH`.

## Operation
- Stream format: a 4-byte header N (word count, MSB first), followed by N words of 4 bytes each, MSB first.
- A byte is accepted when `in_valid && in_ready`. Bytes are shifted into a 32-bit assembly register, and a 2-bit byte counter wraps 3→0.
- FSM states:
  - IDLE:
    - `in_ready=0`.
    - `start` → HDR.
  - HDR:
    - `in_ready=1`.
    - On the 4th accepted byte, latch N.
    - If N=0 → DONE.
    - If N>DEPTH → ERR.
    - Otherwise → DATA, with word index cleared.
  - DATA:
    - `in_ready=1`.
    - On each 4th byte, register a write: `im_we=1`, `im_a`=index, `im_d`=assembled word. The index then increments.
    - When the write of word N-1 is registered → DONE.
  - DONE:
    - `in_ready=0`, `done=1`.
    - `start` → HDR. This clears `done`, reasserts `cpu_rst`, and resets the index and byte counter.
  - ERR:
    - `in_ready=0`, `err=1`.
    - `start` → HDR and clears `err`.
- `start` is ignored in HDR and DATA.
- `cpu_rst = 1` in every state except DONE.
- Width rules:
  - N is a 32-bit unsigned value compared against `DEPTH`.
  - The index is AW+1 bits wide, so N=DEPTH completes without wrap.
  - `im_a` takes the low AW bits of the index.
- RAM contents are never cleared by this block. Words beyond N keep their previous values.

## Timing
- Reset values:
  - State IDLE.
  - `in_ready=0`, `im_we=0`, `im_a=0`, `im_d=0`, `im_byte_addr=BASE`.
  - `cpu_rst=1`, `done=0`, `err=0`.
  - Byte counter and index 0.
- `in_ready` is a registered output that depends only on state. It never depends on `in_valid` in the same cycle.
- Write latency: if the 4th byte of a word is accepted at edge t, `im_we`, `im_a` and `im_d` are valid during cycle t+1. `im_we` is high for exactly one cycle.
- Final word: the state enters DONE at the same edge that raises the final `im_we`. In that cycle `done=1` and `cpu_rst=0`, and the RAM write completes at the next edge. The CPU's first fetch therefore happens no earlier than t+2.
- Stalls: `in_valid` may drop at any point. The assembly register and byte counter hold their values across gaps of any length.
- `rst` in any state, including mid-word or mid-header, returns the block to reset values at the next edge. Partial words are discarded, and no `im_we` is issued at or after that edge.
- If `start` and `rst` are asserted together, `rst` wins.
- Throughput: one byte per cycle; one word every 4 cycles at sustained valid.

## Test plan
- Reset then `start`, stream `00 00 00 02 3C 01 00 40 20 21 00 01` → `im_we` at a=0 with d=`3C010040`, then at a=1 with d=`20210001`, `im_byte_addr` `00400000` then `00400004`; `done=1` and `cpu_rst=0` in the same cycle as the second write.
- Header `00 00 00 00` → DONE directly, no `im_we`, `done=1`.
- Header `00 00 08 01` (2049) → ERR, `err=1`, `in_ready=0`, `cpu_rst=1`, no writes; a subsequent `start` clears `err` and returns `in_ready=1`.
- N=3 with random `in_valid` gaps of 0-5 cycles between bytes → identical writes to the gap-free run, each `im_we` exactly one cycle.
- `rst` asserted after 2 bytes of word 1 → all outputs at reset values next cycle; a new load of N=1 writes a=0 correctly with no stale bytes.
- Load N=DEPTH → last write at a=2047, `im_byte_addr=00401FFC`, `done=1`; a `start` pulse in DONE restarts and raises `cpu_rst`.
